// File: rtl/register_file_if.sv
// Bus bundle between the decode/issue/write-back logic and the register file.
// master = pipeline side (drives addresses, enables, write-back data),
// slave  = register file (returns read data, hazard and busy vector).
interface register_file_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   // Read ports
   logic [ADDR_W-1:0]          SrcReg1;
   logic [ADDR_W-1:0]          SrcReg2;
   logic                       UseSrc1;
   logic                       UseSrc2;
   logic [DATA_W-1:0]          SrcData1;
   logic [DATA_W-1:0]          SrcData2;
   // Write-back port
   logic                       WriteReg;
   logic [ADDR_W-1:0]          DstReg;
   logic [DATA_W-1:0]          DstData;
   // Issue / scoreboard
   logic                       IssueValid;
   logic [ADDR_W-1:0]          IssueDst;
   logic                       Hazard;
   logic [(1<<ADDR_W)-1:0]     BusyVec;

   modport master (
      output SrcReg1, SrcReg2, UseSrc1, UseSrc2,
      output WriteReg, DstReg, DstData,
      output IssueValid, IssueDst,
      input  SrcData1, SrcData2, Hazard, BusyVec
   );

   modport slave (
      input  SrcReg1, SrcReg2, UseSrc1, UseSrc2,
      input  WriteReg, DstReg, DstData,
      input  IssueValid, IssueDst,
      output SrcData1, SrcData2, Hazard, BusyVec
   );
endinterface

// File: rtl/register_file.sv
// 16 x 16-bit architectural register file with write-back bypass and a
// one-bit-per-register pending-write scoreboard for RAW hazard detection.
// R0 reads as zero, ignores writes and is never marked busy.
module register_file #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   register_file_if.slave rf
);
   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [NREG-1:0]   busy_q;
   logic [NREG-1:0]   busy_d;

   logic              wr_en_s;
   logic              iss_en_s;
   logic [DATA_W-1:0] src_data1_s;
   logic [DATA_W-1:0] src_data2_s;
   logic              haz1_s;
   logic              haz2_s;

   // Qualified write-back and issue strobes; R0 is excluded from both.
   always_comb begin
      wr_en_s  = rf.WriteReg   && (rf.DstReg   != {ADDR_W{1'b0}});
      iss_en_s = rf.IssueValid && (rf.IssueDst != {ADDR_W{1'b0}});
   end

   // Next state of the array and scoreboard; issue (newer producer) beats write-back clear.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         regs_d[r] = regs_q[r];
         busy_d[r] = busy_q[r];
         if (r == 0) begin
            regs_d[r] = {DATA_W{1'b0}};
            busy_d[r] = 1'b0;
         end else if (iss_en_s && (rf.IssueDst == ADDR_W'(r))) begin
            busy_d[r] = 1'b1;
            if (wr_en_s && (rf.DstReg == ADDR_W'(r))) begin
               regs_d[r] = rf.DstData;
            end else begin
               regs_d[r] = regs_q[r];
            end
         end else if (wr_en_s && (rf.DstReg == ADDR_W'(r))) begin
            busy_d[r] = 1'b0;
            regs_d[r] = rf.DstData;
         end else begin
            busy_d[r] = busy_q[r];
            regs_d[r] = regs_q[r];
         end
      end
   end

   // State registers with synchronous reset that also discards any same-cycle write or issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= {DATA_W{1'b0}};
         end
         busy_q <= {NREG{1'b0}};
      end else begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= regs_d[r];
         end
         busy_q <= busy_d;
      end
   end

   // Read ports: array data, overridden by same-cycle write-back data on an address match.
   always_comb begin
      if (wr_en_s && (rf.DstReg == rf.SrcReg1)) begin
         src_data1_s = rf.DstData;
      end else begin
         src_data1_s = regs_q[rf.SrcReg1];
      end
      if (wr_en_s && (rf.DstReg == rf.SrcReg2)) begin
         src_data2_s = rf.DstData;
      end else begin
         src_data2_s = regs_q[rf.SrcReg2];
      end
   end

   // RAW hazard from registered busy bits only; a matching write-back this cycle resolves it.
   always_comb begin
      haz1_s = rf.UseSrc1 && (rf.SrcReg1 != {ADDR_W{1'b0}}) && busy_q[rf.SrcReg1]
               && !(rf.WriteReg && (rf.DstReg == rf.SrcReg1));
      haz2_s = rf.UseSrc2 && (rf.SrcReg2 != {ADDR_W{1'b0}}) && busy_q[rf.SrcReg2]
               && !(rf.WriteReg && (rf.DstReg == rf.SrcReg2));
   end

   assign rf.SrcData1 = src_data1_s;
   assign rf.SrcData2 = src_data2_s;
   assign rf.Hazard   = haz1_s | haz2_s;
   assign rf.BusyVec  = busy_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: reset readback, a directed vector
// table for the documented corner cases, then randomized traffic checked
// against an array-based reference model.
module tb_register_file;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;

   register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf_if ();

   register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .rf  (rf_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic        u1;
      logic        u2;
      logic        we;
      logic [3:0]  dst;
      logic [15:0] data;
      logic        iv;
      logic [3:0]  idst;
      logic [15:0] e_d1;
      logic [15:0] e_d2;
      logic        e_haz;
      logic [15:0] e_busy;   // BusyVec after the edge
   } vec_t;

   vec_t tbl [13];

   // Reference model: plain register array and busy flags
   logic [15:0] m_reg  [16];
   logic        m_busy [16];

   function automatic vec_t mk(logic r, logic [3:0] s1, logic [3:0] s2, logic u1, logic u2,
                               logic we, logic [3:0] dst, logic [15:0] data,
                               logic iv, logic [3:0] idst,
                               logic [15:0] e_d1, logic [15:0] e_d2, logic e_haz,
                               logic [15:0] e_busy);
      vec_t v;
      v.rst = r; v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2;
      v.we = we; v.dst = dst; v.data = data; v.iv = iv; v.idst = idst;
      v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_haz = e_haz; v.e_busy = e_busy;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(vec_t v);
      rst                 = v.rst;
      rf_if.SrcReg1       = v.s1;
      rf_if.SrcReg2       = v.s2;
      rf_if.UseSrc1       = v.u1;
      rf_if.UseSrc2       = v.u2;
      rf_if.WriteReg      = v.we;
      rf_if.DstReg        = v.dst;
      rf_if.DstData       = v.data;
      rf_if.IssueValid    = v.iv;
      rf_if.IssueDst      = v.idst;
   endtask

   function automatic logic [15:0] m_read(vec_t v, logic [3:0] a);
      if (a == 4'd0) return 16'h0000;
      if (v.we && v.dst == a) return v.data;
      return m_reg[a];
   endfunction

   function automatic logic m_haz(vec_t v);
      logic h1, h2;
      h1 = v.u1 && v.s1 != 4'd0 && m_busy[v.s1] && !(v.we && v.dst == v.s1);
      h2 = v.u2 && v.s2 != 4'd0 && m_busy[v.s2] && !(v.we && v.dst == v.s2);
      return h1 | h2;
   endfunction

   function automatic logic [15:0] m_busyvec();
      logic [15:0] b;
      for (int i = 0; i < 16; i++) b[i] = m_busy[i];
      return b;
   endfunction

   // Apply the architectural effect of one clock edge to the model.
   task automatic m_update(vec_t v);
      if (v.rst) begin
         for (int i = 0; i < 16; i++) begin
            m_reg[i]  = 16'h0000;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (v.we && v.dst != 4'd0) begin
            m_reg[v.dst]  = v.data;
            m_busy[v.dst] = 1'b0;
         end
         if (v.iv && v.idst != 4'd0) m_busy[v.idst] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      n_total = 0;
      n_pass  = 0;
      for (int i = 0; i < 16; i++) begin
         m_reg[i]  = 16'h0000;
         m_busy[i] = 1'b0;
      end

      //          rst  s1   s2   u1   u2   we   dst  data      iv   idst  e_d1      e_d2      haz  busy
      tbl[0]  = mk(1'b0,4'd3,4'd0,1'b0,1'b0,1'b1,4'd3,16'hA5C3,1'b0,4'd0, 16'hA5C3,16'h0000,1'b0,16'h0000);
      tbl[1]  = mk(1'b0,4'd3,4'd3,1'b0,1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0, 16'hA5C3,16'hA5C3,1'b0,16'h0000);
      tbl[2]  = mk(1'b0,4'd0,4'd3,1'b1,1'b1,1'b1,4'd0,16'hFFFF,1'b1,4'd0, 16'h0000,16'hA5C3,1'b0,16'h0000);
      tbl[3]  = mk(1'b0,4'd0,4'd0,1'b0,1'b0,1'b0,4'd0,16'h0000,1'b1,4'd5, 16'h0000,16'h0000,1'b0,16'h0020);
      tbl[4]  = mk(1'b0,4'd0,4'd5,1'b0,1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0, 16'h0000,16'h0000,1'b1,16'h0020);
      tbl[5]  = mk(1'b0,4'd0,4'd5,1'b0,1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0, 16'h0000,16'h0000,1'b0,16'h0020);
      tbl[6]  = mk(1'b0,4'd5,4'd5,1'b1,1'b1,1'b1,4'd5,16'h1234,1'b0,4'd0, 16'h1234,16'h1234,1'b0,16'h0000);
      tbl[7]  = mk(1'b0,4'd0,4'd0,1'b0,1'b0,1'b0,4'd0,16'h0000,1'b1,4'd7, 16'h0000,16'h0000,1'b0,16'h0080);
      tbl[8]  = mk(1'b0,4'd7,4'd0,1'b1,1'b0,1'b1,4'd7,16'h7777,1'b1,4'd7, 16'h7777,16'h0000,1'b0,16'h0080);
      tbl[9]  = mk(1'b0,4'd7,4'd7,1'b1,1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0, 16'h7777,16'h7777,1'b1,16'h0080);
      tbl[10] = mk(1'b0,4'd0,4'd0,1'b0,1'b0,1'b0,4'd0,16'h0000,1'b1,4'd9, 16'h0000,16'h0000,1'b0,16'h0280);
      tbl[11] = mk(1'b1,4'd9,4'd7,1'b1,1'b1,1'b1,4'd9,16'hBEEF,1'b0,4'd0, 16'hBEEF,16'h7777,1'b1,16'h0000);
      tbl[12] = mk(1'b0,4'd9,4'd7,1'b1,1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0, 16'h0000,16'h0000,1'b0,16'h0000);

      // Initial reset with idle inputs
      v = mk(1'b1,4'd0,4'd0,1'b0,1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,16'h0000,16'h0000,1'b0,16'h0000);
      drive(v);
      tick();
      tick();
      v.rst = 1'b0;
      drive(v);
      #1;

      // Reset readback on every address, both ports
      chk("reset_busyvec", 32'(rf_if.BusyVec), 32'h0);
      for (int a = 0; a < 16; a++) begin
         v.s1 = 4'(a);
         v.s2 = 4'(15 - a);
         v.u1 = 1'b1;
         v.u2 = 1'b1;
         drive(v);
         #1;
         chk("reset_rd1", 32'(rf_if.SrcData1), 32'h0);
         chk("reset_rd2", 32'(rf_if.SrcData2), 32'h0);
         chk("reset_haz", 32'(rf_if.Hazard), 32'h0);
      end
      tick();

      // Directed vector table
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i]);
         #1;
         chk($sformatf("vec%0d_rd1", i), 32'(rf_if.SrcData1), 32'(tbl[i].e_d1));
         chk($sformatf("vec%0d_rd2", i), 32'(rf_if.SrcData2), 32'(tbl[i].e_d2));
         chk($sformatf("vec%0d_haz", i), 32'(rf_if.Hazard),   32'(tbl[i].e_haz));
         m_update(tbl[i]);
         tick();
         chk($sformatf("vec%0d_busy", i), 32'(rf_if.BusyVec), 32'(tbl[i].e_busy));
      end

      // Randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         v.rst  = ($urandom_range(0, 39) == 0);
         v.s1   = 4'($urandom_range(0, 15));
         v.s2   = ($urandom_range(0, 3) == 0) ? v.s1 : 4'($urandom_range(0, 15));
         v.u1   = 1'($urandom_range(0, 1));
         v.u2   = 1'($urandom_range(0, 1));
         v.we   = 1'($urandom_range(0, 1));
         v.dst  = ($urandom_range(0, 2) == 0) ? v.s1 : 4'($urandom_range(0, 15));
         v.data = 16'($urandom);
         v.iv   = 1'($urandom_range(0, 1));
         v.idst = ($urandom_range(0, 3) == 0) ? v.dst : 4'($urandom_range(0, 15));
         drive(v);
         #1;
         chk("rand_rd1", 32'(rf_if.SrcData1), 32'(m_read(v, v.s1)));
         chk("rand_rd2", 32'(rf_if.SrcData2), 32'(m_read(v, v.s2)));
         chk("rand_haz", 32'(rf_if.Hazard),   32'(m_haz(v)));
         m_update(v);
         tick();
         chk("rand_busy", 32'(rf_if.BusyVec), 32'(m_busyvec()));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
